wb_register_arbiter: RTL and testbench

Round-robin Wishbone arbiter that shares one FASM register slave port (the `wb_register` wrapper) among `NUM_MASTERS` requesters, for example the MCU core, a debug/UART bridge and a DMA engine. Each granted request is latched, issued to the slave as a single transfer, and completed back to the owning master with a one-cycle ack. Masters are served fairly; a slave that never acks is cut off by a timeout.

---
 rtl/wb_register_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_register_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_register_arbiter.sv
// ============================================================================
// Module  : wb_register_arbiter
// Brief   : Round-robin Wishbone arbiter sharing one register slave port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_register_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT     = 15
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic                              m_err_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [DATA_WIDTH-1:0]             s_adr_wr_o,
  output logic [DATA_WIDTH-1:0]             s_adr_rd_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i
);

  localparam int              PTR_W        = $clog2(NUM_MASTERS);
  localparam int              IDXW         = PTR_W + 1;
  localparam logic [IDXW-1:0] NUM_M        = IDXW'(NUM_MASTERS);
  localparam logic [7:0]      TIMEOUT_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       grant_q;
  logic [7:0]             cnt_q;
  logic                   s_stb_q, s_we_q;
  logic [DATA_WIDTH-1:0]  s_adr_q, s_dat_q, m_dat_q;
  logic [NUM_MASTERS-1:0] m_ack_q;
  logic                   m_err_q;

  logic                   pick_vld;
  logic [PTR_W-1:0]       pick_idx;
  logic [IDXW-1:0]        rr_idx;
  logic [IDXW-1:0]        ptr_inc;
  logic [PTR_W-1:0]       ptr_next;
  logic [NUM_MASTERS-1:0] grant_onehot;
  logic                   timed_out;

  // Search upward from ptr, wrapping modulo NUM_MASTERS; first requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      rr_idx = {1'b0, ptr_q} + IDXW'(k);
      if (rr_idx >= NUM_M) rr_idx = rr_idx - NUM_M;
      if (!pick_vld && m_stb_i[rr_idx[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx[PTR_W-1:0];
      end
    end
  end

  assign ptr_inc      = {1'b0, grant_q} + IDXW'(1);
  assign ptr_next     = (ptr_inc >= NUM_M) ? '0 : ptr_inc[PTR_W-1:0];
  assign grant_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << grant_q;
  assign timed_out    = (cnt_q == TIMEOUT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = BUSY;
      BUSY:    if (s_ack_i || timed_out) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      s_stb_q <= 1'b0;
      s_we_q  <= 1'b0;
      s_adr_q <= '0;
      s_dat_q <= '0;
      m_dat_q <= '0;
      m_ack_q <= '0;
      m_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= pick_idx;
            s_stb_q <= 1'b1;
            s_we_q  <= m_we_i[pick_idx];
            s_adr_q <= m_adr_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            s_dat_q <= m_dat_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 8'd1;
          // A late ack in the timeout cycle still completes normally.
          if (s_ack_i) begin
            m_dat_q <= s_dat_i;
            m_err_q <= 1'b0;
            m_ack_q <= grant_onehot;
            s_stb_q <= 1'b0;
          end else if (timed_out) begin
            m_dat_q <= '0;
            m_err_q <= 1'b1;
            m_ack_q <= grant_onehot;
            s_stb_q <= 1'b0;
          end
        end
        DONE: begin
          m_ack_q <= '0;
          m_err_q <= 1'b0;
          cnt_q   <= '0;
          ptr_q   <= ptr_next;
        end
        default: ;
      endcase
    end
  end

  assign m_dat_o    = m_dat_q;
  assign m_ack_o    = m_ack_q;
  assign m_err_o    = m_err_q;
  assign s_stb_o    = s_stb_q;
  assign s_we_o     = s_we_q;
  assign s_adr_wr_o = s_adr_q;
  assign s_adr_rd_o = s_adr_q;
  assign s_dat_o    = s_dat_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_register_arbiter.sv
// ============================================================================
// Module  : tb_wb_register_arbiter
// Brief   : Scoreboard bench for the round-robin register-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wb_register_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  m_stb_i, m_we_i;
  logic [15:0] m_adr_i, m_dat_i;
  logic [7:0]  m_dat_o;
  logic [1:0]  m_ack_o;
  logic        m_err_o;
  logic        s_stb_o, s_we_o;
  logic [7:0]  s_adr_wr_o, s_adr_rd_o, s_dat_o;
  logic [7:0]  s_dat_i;
  logic        s_ack_i;
  logic        slave_en;
  int          cyc;
  int          n_cmp, n_bad;

  typedef struct {logic [1:0] ack; logic [7:0] dat; logic err; int cy;} mexp_t;
  typedef struct {logic we; logic [7:0] adr; logic [7:0] dat; int cy;} sexp_t;
  mexp_t mq[$];
  sexp_t sq[$];

  wb_register_arbiter #(.NUM_MASTERS(2), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_wr_o(s_adr_wr_o),
    .s_adr_rd_o(s_adr_rd_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  // Zero-wait register slave: acks in the same cycle as the strobe.
  assign s_ack_i = s_stb_o & slave_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic req(input int i, input logic we, input logic [7:0] adr, input logic [7:0] dat);
    m_stb_i[i]          = 1'b1;
    m_we_i[i]           = we;
    m_adr_i[i*8 +: 8]   = adr;
    m_dat_i[i*8 +: 8]   = dat;
  endtask

  task automatic push_m(input int i, input logic [7:0] dat, input logic err, input int cy);
    mexp_t e;
    e.ack = 2'b01 << i; e.dat = dat; e.err = err; e.cy = cy;
    mq.push_back(e);
  endtask

  task automatic push_s(input logic we, input logic [7:0] adr, input logic [7:0] dat, input int cy);
    sexp_t e;
    e.we = we; e.adr = adr; e.dat = dat; e.cy = cy;
    sq.push_back(e);
  endtask

  // Wait (bounded) for n acks; optionally release each master as it is acked.
  task automatic wait_acks(input int n, input bit drop, input int budget);
    int got = 0;
    int t   = 0;
    while (got < n && t < budget) begin
      @(negedge clk);
      t++;
      for (int i = 0; i < 2; i++)
        if (m_ack_o[i]) begin
          got++;
          if (drop) m_stb_i[i] = 1'b0;
        end
    end
    if (got < n) chk("ack_wait_expired", 32'(got), 32'(n));
  endtask

  initial begin
    int c;
    cyc = 0; n_cmp = 0; n_bad = 0;
    reset_n = 1'b0; slave_en = 1'b1; s_dat_i = 8'h00;
    m_stb_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0;

    fork
      forever begin
        @(negedge clk);
        if (s_stb_o && s_ack_i) begin
          if (sq.size() == 0) chk("unexpected_slave_xfer", 32'(s_adr_wr_o), 32'hFFFF_FFFF);
          else begin
            sexp_t e;
            e = sq.pop_front();
            chk("s_we", 32'(s_we_o), 32'(e.we));
            chk("s_adr_wr", 32'(s_adr_wr_o), 32'(e.adr));
            chk("s_adr_rd", 32'(s_adr_rd_o), 32'(e.adr));
            chk("s_dat", 32'(s_dat_o), 32'(e.dat));
            chk("s_cycle", 32'(cyc), 32'(e.cy));
          end
        end
        if (m_ack_o != 2'b00) begin
          if (mq.size() == 0) chk("unexpected_ack", 32'(m_ack_o), 32'h0);
          else begin
            mexp_t e;
            e = mq.pop_front();
            chk("m_ack", 32'(m_ack_o), 32'(e.ack));
            chk("m_dat", 32'(m_dat_o), 32'(e.dat));
            chk("m_err", 32'(m_err_o), 32'(e.err));
            chk("ack_cycle", 32'(cyc), 32'(e.cy));
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_stb", 32'(s_stb_o), 32'h0);
    chk("rst_m_ack", 32'(m_ack_o), 32'h0);
    chk("rst_m_err", 32'(m_err_o), 32'h0);
    chk("rst_m_dat", 32'(m_dat_o), 32'h0);
    chk("rst_s_we", 32'(s_we_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single write from master 0
    @(negedge clk); c = cyc; s_dat_i = 8'h00;
    req(0, 1'b1, 8'h80, 8'h5A);
    push_s(1'b1, 8'h80, 8'h5A, c + 1); push_m(0, 8'h00, 1'b0, c + 2);
    wait_acks(1, 1'b1, 10);

    // Read from master 1
    @(negedge clk); c = cyc; s_dat_i = 8'hC3;
    req(1, 1'b0, 8'h81, 8'h00);
    push_s(1'b0, 8'h81, 8'h00, c + 1); push_m(1, 8'hC3, 1'b0, c + 2);
    wait_acks(1, 1'b1, 10);

    // Contention with ptr back at 0
    @(negedge clk); c = cyc; s_dat_i = 8'h3C;
    req(0, 1'b1, 8'h10, 8'h11); req(1, 1'b0, 8'h20, 8'h00);
    push_s(1'b1, 8'h10, 8'h11, c + 1); push_m(0, 8'h3C, 1'b0, c + 2);
    push_s(1'b0, 8'h20, 8'h00, c + 4); push_m(1, 8'h3C, 1'b0, c + 5);
    wait_acks(2, 1'b1, 20);

    // Fairness: both hold requests for six transfers
    @(negedge clk); c = cyc; s_dat_i = 8'h77;
    req(0, 1'b1, 8'hA0, 8'h0A); req(1, 1'b0, 8'hB1, 8'h00);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) push_s(1'b1, 8'hA0, 8'h0A, c + 1 + 3*k);
      else            push_s(1'b0, 8'hB1, 8'h00, c + 1 + 3*k);
      push_m(k % 2, 8'h77, 1'b0, c + 2 + 3*k);
    end
    wait_acks(6, 1'b0, 40);
    m_stb_i = 2'b00;

    // Timeout: slave never acks
    @(negedge clk); c = cyc; slave_en = 1'b0; s_dat_i = 8'hEE;
    req(0, 1'b0, 8'h55, 8'h00);
    push_m(0, 8'h00, 1'b1, c + 16);
    wait_acks(1, 1'b1, 40);

    // Next request after timeout is served normally
    @(negedge clk); c = cyc; slave_en = 1'b1; s_dat_i = 8'h99;
    req(1, 1'b0, 8'h66, 8'h00);
    push_s(1'b0, 8'h66, 8'h00, c + 1); push_m(1, 8'h99, 1'b0, c + 2);
    wait_acks(1, 1'b1, 10);

    // Leave ptr at 1 before the reset test
    @(negedge clk); c = cyc; s_dat_i = 8'h00;
    req(0, 1'b1, 8'h01, 8'h02);
    push_s(1'b1, 8'h01, 8'h02, c + 1); push_m(0, 8'h00, 1'b0, c + 2);
    wait_acks(1, 1'b1, 10);

    // Reset mid-transfer
    @(negedge clk); slave_en = 1'b0;
    req(1, 1'b0, 8'h42, 8'h00);
    repeat (3) @(negedge clk);
    chk("busy_s_stb", 32'(s_stb_o), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_s_stb_drop", 32'(s_stb_o), 32'h0);
    chk("reset_m_ack", 32'(m_ack_o), 32'h0);
    m_stb_i = 2'b00;
    repeat (2) @(negedge clk);
    reset_n = 1'b1; slave_en = 1'b1;

    // Pointer must be 0 again: master 0 wins the tie
    @(negedge clk); c = cyc; s_dat_i = 8'hAB;
    req(0, 1'b1, 8'h30, 8'h31); req(1, 1'b0, 8'h32, 8'h00);
    push_s(1'b1, 8'h30, 8'h31, c + 1); push_m(0, 8'hAB, 1'b0, c + 2);
    push_s(1'b0, 8'h32, 8'h00, c + 4); push_m(1, 8'hAB, 1'b0, c + 5);
    wait_acks(2, 1'b1, 20);

    repeat (4) @(negedge clk);
    chk("m_queue_drained", 32'(mq.size()), 32'h0);
    chk("s_queue_drained", 32'(sq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
